// File: rtl/softmax_argmax_unit.sv
// softmax_argmax_unit: captures a probability vector, scans it one element per cycle, holds argmax result until accepted.
// Optional SOFTMAX_TOP2_EN adds runner-up index/confidence and the top-1/top-2 margin.
module softmax_argmax_unit #(
  parameter int NUM_CLASSES = 10,
  parameter int DATA_W = 16,
  parameter int IDX_W = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_CLASSES*DATA_W-1:0] softmax_in,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic [IDX_W-1:0]              class_idx,
  output logic [DATA_W-1:0]             class_conf,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          busy,
  output logic [7:0]                    dropped_cnt
`ifdef SOFTMAX_TOP2_EN
  ,
  output logic [IDX_W-1:0]              second_idx,
  output logic [DATA_W-1:0]             second_conf,
  output logic [DATA_W-1:0]             margin
`endif
);
  typedef enum logic [1:0] {IDLE, SCAN, HOLD} state_t;
  state_t state, state_d;
  logic [NUM_CLASSES*DATA_W-1:0] vec_q;
  logic [DATA_W-1:0] best_val, elem, nb_val;
  logic [IDX_W-1:0] best_idx, cnt, nb_idx;
  logic gt, last, capture;
  assign elem = vec_q[cnt*DATA_W +: DATA_W];
  assign gt = elem > best_val;
  assign last = cnt == IDX_W'(NUM_CLASSES - 1);
  assign nb_val = gt ? elem : best_val;
  assign nb_idx = gt ? cnt : best_idx;
  assign capture = state == IDLE && in_valid;
`ifdef SOFTMAX_TOP2_EN
  logic [DATA_W-1:0] second_val, ns_val;
  logic [IDX_W-1:0] second_idx_q, ns_idx;
  // A new best demotes the old best; otherwise a strictly larger element replaces the runner-up.
  assign ns_val = gt ? best_val : (elem > second_val) ? elem : second_val;
  assign ns_idx = gt ? best_idx : (elem > second_val) ? cnt : second_idx_q;
  assign margin = class_conf - second_conf;
`endif
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= state_d;
  always_comb begin
    state_d = capture ? SCAN :
              (state == SCAN && last) ? HOLD :
              (state == HOLD && out_ready) ? IDLE : state;
  end
  always_comb begin
    in_ready = state == IDLE;
    busy = state != IDLE;
    out_valid = state == HOLD;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      vec_q <= '0;
      best_val <= '0;
      best_idx <= '0;
      cnt <= '0;
      class_idx <= '0;
      class_conf <= '0;
      dropped_cnt <= '0;
`ifdef SOFTMAX_TOP2_EN
      second_val <= '0;
      second_idx_q <= '0;
      second_idx <= '0;
      second_conf <= '0;
`endif
    end else begin
      if (in_valid && !in_ready && dropped_cnt != 8'hFF) dropped_cnt <= dropped_cnt + 8'd1;
      if (capture) begin
        vec_q <= softmax_in;
        best_val <= '0;
        best_idx <= '0;
        cnt <= '0;
`ifdef SOFTMAX_TOP2_EN
        second_val <= '0;
        second_idx_q <= '0;
`endif
      end
      if (state == SCAN) begin
        best_val <= nb_val;
        best_idx <= nb_idx;
        cnt <= cnt + IDX_W'(1);
`ifdef SOFTMAX_TOP2_EN
        second_val <= ns_val;
        second_idx_q <= ns_idx;
`endif
        if (last) begin
          class_idx <= nb_idx;
          class_conf <= nb_val;
`ifdef SOFTMAX_TOP2_EN
          second_idx <= ns_idx;
          second_conf <= ns_val;
`endif
        end
      end
    end
endmodule

// File: tb/tb_softmax_argmax_unit.sv
// tb_softmax_argmax_unit: directed vectors with hand-computed argmax results, latency, backpressure and reset checks.
module tb_softmax_argmax_unit;
  localparam int N = 10;
  localparam int W = 16;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [N*W-1:0] softmax_in = '0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic in_ready, out_valid, busy;
  logic [3:0] class_idx;
  logic [W-1:0] class_conf;
  logic [7:0] dropped_cnt;
  int n_chk = 0;
  int n_fail = 0;
`ifdef SOFTMAX_TOP2_EN
  logic [3:0] second_idx;
  logic [W-1:0] second_conf, margin;
`endif
  softmax_argmax_unit dut (
    .clk(clk), .rst(rst), .softmax_in(softmax_in), .in_valid(in_valid), .in_ready(in_ready),
    .class_idx(class_idx), .class_conf(class_conf), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .dropped_cnt(dropped_cnt)
`ifdef SOFTMAX_TOP2_EN
    , .second_idx(second_idx), .second_conf(second_conf), .margin(margin)
`endif
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask
  function automatic logic [N*W-1:0] mk(input logic [W-1:0] base, input int i1, input logic [W-1:0] v1,
                                        input int i2, input logic [W-1:0] v2);
    logic [N*W-1:0] v;
    for (int i = 0; i < N; i++) v[i*W +: W] = base;
    v[i1*W +: W] = v1;
    if (i2 >= 0) v[i2*W +: W] = v2;
    return v;
  endfunction
  task automatic send(input logic [N*W-1:0] v);
    @(negedge clk);
    softmax_in = v;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask
  task automatic send_wait(input string tag, input logic [N*W-1:0] v);
    send(v);
    check({tag, "_busy"}, busy, 1);
    check({tag, "_in_ready_low"}, in_ready, 0);
    repeat (9) @(negedge clk);
    check({tag, "_not_early"}, out_valid, 0);
    @(negedge clk);
    check({tag, "_out_valid"}, out_valid, 1);
  endtask
  task automatic handshake(input string tag);
    check({tag, "_in_ready_hold"}, in_ready, 0);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_ov_drop"}, out_valid, 0);
    check({tag, "_in_ready_back"}, in_ready, 1);
  endtask
  initial begin
    #2;
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_idx", class_idx, 0);
    check("rst_conf", class_conf, 0);
    check("rst_dropped", dropped_cnt, 0);
    @(negedge clk);
    rst = 1'b1;
    // 1: single clear winner
    send_wait("t1", mk(16'h0200, 7, 16'h6000, -1, 0));
    check("t1_idx", class_idx, 7);
    check("t1_conf", class_conf, 16'h6000);
    @(negedge clk);
    check("t1_held", out_valid, 1);
    handshake("t1");
    // 2: tie resolves to lowest index; input changes after capture ignored
    send(mk(16'h0100, 2, 16'h4000, 5, 16'h4000));
    softmax_in = mk(16'h7FFF, 0, 16'h7FFF, -1, 0);
    repeat (10) @(negedge clk);
    check("t2_out_valid", out_valid, 1);
    check("t2_idx", class_idx, 2);
    check("t2_conf", class_conf, 16'h4000);
    handshake("t2");
    check("t2_idx_kept", class_idx, 2);
    // 3: all zero
    send_wait("t3", '0);
    check("t3_idx", class_idx, 0);
    check("t3_conf", class_conf, 0);
    handshake("t3");
    // 4: backpressure with dropped pulses, then saturation
    send_wait("t4", mk(16'h0010, 4, 16'h1234, -1, 0));
    for (int i = 0; i < 20; i++) begin
      in_valid = (i == 3 || i == 8 || i == 13);
      softmax_in = mk(16'h7FFF, 0, 16'h7FFF, -1, 0);
      @(negedge clk);
      in_valid = 1'b0;
      if (i % 5 == 0) check("t4_idx_stable", class_idx, 4);
    end
    check("t4_out_valid", out_valid, 1);
    check("t4_conf", class_conf, 16'h1234);
    check("t4_dropped", dropped_cnt, 3);
    in_valid = 1'b1;
    repeat (260) @(negedge clk);
    in_valid = 1'b0;
    check("t4_dropped_sat", dropped_cnt, 255);
    handshake("t4");
    check("t4_idx_after", class_idx, 4);
    // 5: asynchronous reset mid-scan
    send(mk(16'h0300, 1, 16'h5000, -1, 0));
    repeat (3) @(negedge clk);
    check("t5_scanning", busy, 1);
    #2 rst = 1'b0;
    #1;
    check("t5_rst_busy", busy, 0);
    check("t5_rst_ov", out_valid, 0);
    check("t5_rst_dropped", dropped_cnt, 0);
    check("t5_rst_idx", class_idx, 0);
    @(negedge clk);
    rst = 1'b1;
    send_wait("t5", mk(16'h0100, 9, 16'h7FFF, -1, 0));
    check("t5_idx", class_idx, 9);
    check("t5_conf", class_conf, 16'h7FFF);
    handshake("t5");
`ifdef SOFTMAX_TOP2_EN
    // 6: top-2 tracking
    send_wait("t6", mk(16'h0400, 3, 16'h5000, 8, 16'h3000));
    check("t6_idx", class_idx, 3);
    check("t6_second_idx", second_idx, 8);
    check("t6_second_conf", second_conf, 16'h3000);
    check("t6_margin", margin, 16'h2000);
    handshake("t6");
    send_wait("t6b", mk(16'h0100, 2, 16'h4000, 5, 16'h4000));
    check("t6b_idx", class_idx, 2);
    check("t6b_second_idx", second_idx, 5);
    check("t6b_margin", margin, 0);
    handshake("t6b");
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
